// File: rtl/dca_matrix_store_sequencer.sv
// Matrix store sequencer: walks a matrix row by row, issuing one AXI AW burst and
// one write-data transaction record per row, and tracks outstanding B responses.
module dca_matrix_store_sequencer #(
    parameter int unsigned BW_ADDR         = 32,
    parameter int unsigned BW_AXI_DATA     = 32,
    parameter int unsigned BW_ELEMENT      = 32,
    parameter int unsigned BW_DIM          = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                inst_valid,
    output logic                inst_ready,
    input  logic [BW_ADDR-1:0]  inst_addr,
    input  logic [BW_ADDR-1:0]  inst_stride,
    input  logic [BW_DIM-1:0]   inst_num_row_m1,
    input  logic [BW_DIM-1:0]   inst_num_col_m1,
    output logic                awvalid,
    input  logic                awready,
    output logic [BW_ADDR-1:0]  awaddr,
    output logic [7:0]          awlen,
    output logic                txn_valid,
    input  logic                txn_ready,
    output logic [BW_DIM+8:0]   txn_info,
    input  logic                bvalid,
    output logic                bready,
    input  logic [1:0]          bresp,
    output logic                done,
    output logic                error
);

    localparam int unsigned BYTES_PER_BEAT = BW_AXI_DATA / 8;
    localparam int unsigned BYTES_PER_ELEM = BW_ELEMENT / 8;
    localparam int unsigned BW_OUT         = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [BW_DIM-1:0]   r_num_row_m1;
    logic [BW_ADDR-1:0]  r_stride;
    logic [BW_ADDR-1:0]  r_row_addr;
    logic [BW_DIM-1:0]   r_row_idx;
    logic [7:0]          r_awlen;
    logic                r_is_last;
    logic                r_awvalid;
    logic                r_txn_valid;
    logic                r_aw_acc;
    logic                r_txn_acc;
    logic [BW_OUT-1:0]   r_outstanding;
    logic                r_done;
    logic                r_error;

    logic                w_accept;
    logic                w_bready;
    logic                w_aw_hs;
    logic                w_txn_hs;
    logic                w_b_hs;
    logic                w_row_done;
    logic                w_row_idle;
    logic                w_can_issue;
    logic                w_misaligned;
    logic [BW_OUT-1:0]   w_out_nxt;
    logic [BW_DIM-1:0]   w_next_idx;
    logic [31:0]         w_row_bytes;
    logic [31:0]         w_beats;
    logic [7:0]          w_awlen;

    assign inst_ready = (r_state == S_IDLE);
    assign w_bready   = (r_state == S_ISSUE) || (r_state == S_DRAIN);
    assign bready     = w_bready;
    assign awvalid    = r_awvalid;
    assign awaddr     = r_row_addr;
    assign awlen      = r_awlen;
    assign txn_valid  = r_txn_valid;
    assign txn_info   = {r_is_last, r_awlen, r_row_idx};
    assign done       = r_done;
    assign error      = r_error;

    assign w_accept   = inst_valid && (r_state == S_IDLE);
    assign w_aw_hs    = r_awvalid && awready;
    assign w_txn_hs   = r_txn_valid && txn_ready;
    assign w_b_hs     = bvalid && w_bready;

    // A row is finished once both its AW and its txn record have been taken, in any order
    assign w_row_done = (r_aw_acc || w_aw_hs) && (r_txn_acc || w_txn_hs);
    assign w_row_idle = !(r_awvalid || r_aw_acc || r_txn_valid || r_txn_acc);
    assign w_next_idx = r_row_idx + BW_DIM'(1);

    // Burst length of one row, rounded up to whole beats
    assign w_row_bytes  = (32'(inst_num_col_m1) + 32'd1) * 32'(BYTES_PER_ELEM);
    assign w_beats      = (w_row_bytes + 32'(BYTES_PER_BEAT) - 32'd1) / 32'(BYTES_PER_BEAT);
    assign w_awlen      = 8'(w_beats - 32'd1);
    assign w_misaligned = (inst_addr % BW_ADDR'(BYTES_PER_BEAT)) != '0;

    // Outstanding count after this cycle's AW and B handshakes, saturating at zero
    always_comb begin
        w_out_nxt = r_outstanding;
        if (w_aw_hs && !w_b_hs) begin
            w_out_nxt = r_outstanding + BW_OUT'(1);
        end else if (!w_aw_hs && w_b_hs && (r_outstanding != '0)) begin
            w_out_nxt = r_outstanding - BW_OUT'(1);
        end
    end

    assign w_can_issue = (w_out_nxt < BW_OUT'(MAX_OUTSTANDING));

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            r_state       <= S_IDLE;
            r_num_row_m1  <= '0;
            r_stride      <= '0;
            r_row_addr    <= '0;
            r_row_idx     <= '0;
            r_awlen       <= '0;
            r_is_last     <= 1'b0;
            r_awvalid     <= 1'b0;
            r_txn_valid   <= 1'b0;
            r_aw_acc      <= 1'b0;
            r_txn_acc     <= 1'b0;
            r_outstanding <= '0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_nxt;
            if (w_b_hs && ((bresp != 2'b00) || (r_outstanding == '0))) begin
                r_error <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_num_row_m1 <= inst_num_row_m1;
                        r_stride     <= inst_stride;
                        r_row_addr   <= inst_addr;
                        r_row_idx    <= '0;
                        r_awlen      <= w_awlen;
                        r_is_last    <= (inst_num_row_m1 == '0);
                        r_error      <= w_misaligned;
                        r_awvalid    <= 1'b1;
                        r_txn_valid  <= 1'b1;
                        r_aw_acc     <= 1'b0;
                        r_txn_acc    <= 1'b0;
                        r_state      <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_acc  <= 1'b1;
                    end
                    if (w_txn_hs) begin
                        r_txn_valid <= 1'b0;
                        r_txn_acc   <= 1'b1;
                    end
                    if (w_row_done) begin
                        r_aw_acc  <= 1'b0;
                        r_txn_acc <= 1'b0;
                        if (r_is_last) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_row_idx  <= w_next_idx;
                            r_row_addr <= r_row_addr + r_stride;
                            r_is_last  <= (w_next_idx == r_num_row_m1);
                            if (w_can_issue) begin
                                r_awvalid   <= 1'b1;
                                r_txn_valid <= 1'b1;
                            end
                        end
                    end else if (w_row_idle && w_can_issue) begin
                        r_awvalid   <= 1'b1;
                        r_txn_valid <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (w_out_nxt == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dca_matrix_store_sequencer.sv
// Directed bench for the matrix store sequencer: table of full stores plus
// hand-written sequences for backpressure, B timing, errors and reset.
module tb_dca_matrix_store_sequencer;

    logic        clk;
    logic        rstnn;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [31:0] inst_stride;
    logic [3:0]  inst_num_row_m1;
    logic [3:0]  inst_num_col_m1;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        txn_valid;
    logic        txn_ready;
    logic [12:0] txn_info;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [1:0]  bresp = 2'b00;
    logic        done;
    logic        error;

    dca_matrix_store_sequencer #(
        .BW_ADDR(32), .BW_AXI_DATA(32), .BW_ELEMENT(32), .BW_DIM(4), .MAX_OUTSTANDING(2)
    ) u_dut (
        .clk(clk), .rstnn(rstnn),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_addr(inst_addr), .inst_stride(inst_stride),
        .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_info(txn_info),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .done(done), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Observation log filled by the negedge monitor
    logic [31:0] aw_addr_q[$];
    logic [7:0]  aw_len_q[$];
    int          aw_cyc_q[$];
    logic [12:0] txn_q[$];
    int          acc_cyc  = 0;
    int          done_cnt = 0;
    int          pend     = 0;
    int          b_cnt    = 0;

    // B responder controls
    logic        b_hold   = 1'b0;
    logic        b_stray  = 1'b0;
    int          b_err_at = -1;

    always @(posedge clk) cyc++;

    // Record handshakes just before the edge that completes them
    always @(negedge clk) begin
        if (!rstnn) begin
            pend = 0;
        end else begin
            if (inst_valid && inst_ready) acc_cyc = cyc;
            if (awvalid && awready) begin
                aw_addr_q.push_back(awaddr);
                aw_len_q.push_back(awlen);
                aw_cyc_q.push_back(cyc);
                pend++;
            end
            if (txn_valid && txn_ready) txn_q.push_back(txn_info);
            if (bvalid && bready) begin
                if (pend > 0) pend--;
                b_cnt++;
            end
            if (done) done_cnt++;
        end
    end

    // B channel model: one response per accepted AW, in order
    always @(posedge clk) begin
        #2;
        bvalid = b_stray || (!b_hold && (pend > 0));
        bresp  = (bvalid && (b_cnt == b_err_at)) ? 2'b10 : 2'b00;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_awvalid"},    32'(awvalid), 32'd0);
        chk({tag, "_txn_valid"},  32'(txn_valid), 32'd0);
        chk({tag, "_awaddr"},     awaddr, 32'd0);
        chk({tag, "_awlen"},      32'(awlen), 32'd0);
        chk({tag, "_txn_info"},   32'(txn_info), 32'd0);
        chk({tag, "_bready"},     32'(bready), 32'd0);
        chk({tag, "_done"},       32'(done), 32'd0);
        chk({tag, "_error"},      32'(error), 32'd0);
        chk({tag, "_inst_ready"}, 32'(inst_ready), 32'd1);
    endtask

    // Present one instruction; returns at accept edge + 1
    task automatic start_store(input logic [31:0] a, input logic [31:0] s,
                               input logic [3:0] r, input logic [3:0] c);
        int k;
        for (k = 0; k < 50 && !inst_ready; k++) tick();
        chk("inst_ready_wait", 32'(inst_ready), 32'd1);
        inst_addr       = a;
        inst_stride     = s;
        inst_num_row_m1 = r;
        inst_num_col_m1 = c;
        inst_valid      = 1'b1;
        tick();
        inst_valid      = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            tick();
            if (done_cnt > base) ok = 1'b1;
        end
        chk({name, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] stride;
        logic [3:0]  nrow_m1;
        logic [3:0]  ncol_m1;
        int          err_row;
        logic [7:0]  exp_awlen;
        logic        exp_err;
        logic [31:0] exp_last_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int a0, t0, d0, rows;
        logic [12:0] ti;

        vecs[0] = '{32'h0000_1000, 32'h0000_0040, 4'd3,  4'd3,  -1, 8'd3,  1'b0, 32'h0000_10C0};
        vecs[1] = '{32'h0000_3000, 32'h0000_0020, 4'd3,  4'd1,   2, 8'd1,  1'b1, 32'h0000_3060};
        vecs[2] = '{32'h0000_0040, 32'hFFFF_FFC0, 4'd2,  4'd0,  -1, 8'd0,  1'b0, 32'hFFFF_FFC0};
        vecs[3] = '{32'h0000_2002, 32'h0000_0100, 4'd0,  4'd7,  -1, 8'd7,  1'b1, 32'h0000_2002};
        vecs[4] = '{32'h0000_0000, 32'h0000_0010, 4'd15, 4'd15, -1, 8'd15, 1'b0, 32'h0000_00F0};

        rstnn = 1'b0; inst_valid = 1'b0; inst_addr = '0; inst_stride = '0;
        inst_num_row_m1 = '0; inst_num_col_m1 = '0; awready = 1'b1; txn_ready = 1'b1;
        repeat (3) tick();
        chk_idle_outputs("reset");
        rstnn = 1'b1;
        tick();

        // Full stores with all readies high and immediate B responses
        foreach (vecs[i]) begin
            a0 = aw_addr_q.size(); t0 = txn_q.size(); d0 = done_cnt;
            rows = int'(vecs[i].nrow_m1) + 1;
            b_err_at = (vecs[i].err_row >= 0) ? b_cnt + vecs[i].err_row : -1;
            start_store(vecs[i].addr, vecs[i].stride, vecs[i].nrow_m1, vecs[i].ncol_m1);
            wait_done($sformatf("v%0d", i), d0);
            tick();
            b_err_at = -1;
            chk($sformatf("v%0d_aw_count", i), 32'(aw_addr_q.size() - a0), 32'(rows));
            chk($sformatf("v%0d_txn_count", i), 32'(txn_q.size() - t0), 32'(rows));
            chk($sformatf("v%0d_first_addr", i), aw_addr_q[a0], vecs[i].addr);
            chk($sformatf("v%0d_last_addr", i), aw_addr_q[a0 + rows - 1], vecs[i].exp_last_addr);
            chk($sformatf("v%0d_awlen", i), 32'(aw_len_q[a0 + rows - 1]), 32'(vecs[i].exp_awlen));
            chk($sformatf("v%0d_first_latency", i), 32'(aw_cyc_q[a0] - acc_cyc), 32'd1);
            chk($sformatf("v%0d_back_to_back", i), 32'(aw_cyc_q[a0 + rows - 1] - aw_cyc_q[a0]), 32'(rows - 1));
            ti = txn_q[t0 + rows - 1];
            chk($sformatf("v%0d_last_txn", i), 32'(ti), 32'({1'b1, vecs[i].exp_awlen, vecs[i].nrow_m1}));
            ti = txn_q[t0];
            chk($sformatf("v%0d_first_txn_last", i), 32'(ti[12]), 32'(rows == 1));
            chk($sformatf("v%0d_done_pulses", i), 32'(done_cnt - d0), 32'd1);
            chk($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_err));
        end

        // Stray B with nothing outstanding, AW held off meanwhile
        d0 = done_cnt;
        start_store(32'h5000, 32'h40, 4'd1, 4'd0);
        awready = 1'b0;
        b_stray = 1'b1;
        tick();
        b_stray = 1'b0;
        chk("stray_error", 32'(error), 32'd1);
        chk("stray_aw_held", 32'(awvalid), 32'd1);
        chk("stray_aw_addr", awaddr, 32'h5000);
        awready = 1'b1;
        wait_done("stray", d0);
        chk("stray_error_held", 32'(error), 32'd1);

        // Outstanding limit of 2 with B held off
        b_hold = 1'b1;
        a0 = aw_addr_q.size(); d0 = done_cnt;
        start_store(32'h6000, 32'h100, 4'd3, 4'd0);
        chk("limit_error_cleared", 32'(error), 32'd0);
        repeat (8) tick();
        chk("limit_aw_count2", 32'(aw_addr_q.size() - a0), 32'd2);
        chk("limit_awvalid_low", 32'(awvalid), 32'd0);
        b_hold = 1'b0;
        tick();
        b_hold = 1'b1;
        repeat (4) tick();
        chk("limit_aw_count3", 32'(aw_addr_q.size() - a0), 32'd3);
        chk("limit_awvalid_low2", 32'(awvalid), 32'd0);
        chk("limit_third_addr", aw_addr_q[a0 + 2], 32'h6200);
        b_hold = 1'b0;
        wait_done("limit", d0);
        chk("limit_aw_count4", 32'(aw_addr_q.size() - a0), 32'd4);

        // txn record held off: AW taken once, row waits for the record
        txn_ready = 1'b0;
        a0 = aw_addr_q.size(); d0 = done_cnt;
        start_store(32'h7000, 32'h40, 4'd1, 4'd3);
        repeat (4) tick();
        chk("txnwait_aw_count", 32'(aw_addr_q.size() - a0), 32'd1);
        chk("txnwait_awvalid", 32'(awvalid), 32'd0);
        chk("txnwait_txn_valid", 32'(txn_valid), 32'd1);
        chk("txnwait_txn_info", 32'(txn_info), 32'h030);
        chk("txnwait_awaddr", awaddr, 32'h7000);
        txn_ready = 1'b1;
        wait_done("txnwait", d0);
        chk("txnwait_aw_count2", 32'(aw_addr_q.size() - a0), 32'd2);
        chk("txnwait_second_addr", aw_addr_q[a0 + 1], 32'h7040);

        // Last AW and a B in the same cycle, final B right after
        b_hold = 1'b1; awready = 1'b0;
        d0 = done_cnt;
        start_store(32'h8000, 32'h40, 4'd1, 4'd0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        tick();
        chk("simul_awvalid", 32'(awvalid), 32'd1);
        chk("simul_awaddr", awaddr, 32'h8040);
        b_hold = 1'b0; awready = 1'b1;
        tick();
        chk("simul_no_done_yet", 32'(done), 32'd0);
        chk("simul_bready_drain", 32'(bready), 32'd1);
        tick();
        chk("simul_done_pulse", 32'(done), 32'd1);
        tick();
        chk("simul_done_drop", 32'(done), 32'd0);
        chk("simul_error", 32'(error), 32'd0);
        chk("simul_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset in the middle of a store
        b_hold = 1'b1;
        start_store(32'h9001, 32'h40, 4'd7, 4'd0);
        repeat (3) tick();
        chk("prereset_error", 32'(error), 32'd1);
        d0 = done_cnt;
        rstnn = 1'b0;
        #2;
        chk_idle_outputs("midreset");
        b_hold = 1'b0;
        repeat (2) tick();
        rstnn = 1'b1;
        repeat (6) tick();
        chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midreset_idle", 32'(inst_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
